datamem_bytelane: RTL and testbench

- Parametrised data memory for the single-cycle/multi-cycle CPU datapath.
- Byte-addressed; supports byte, halfword and word loads/stores with lane selection and sign/zero extension.
- Registered read with a one-cycle valid strobe; misaligned accesses are flagged.
- Replaces the all-at-once reset clear with a sequential init sweep (one word per cycle), so it maps to block RAM.

---
 rtl/datamem_pkg.sv | 31 +++
 rtl/datamem_load_align.sv | 33 +++
 rtl/datamem_bytelane.sv | 132 +++++++++++++
 tb/tb_datamem_bytelane.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datamem_pkg.sv
// Shared encodings and lane helpers for the byte-lane data memory.
package datamem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_e;

   // Halves must sit on even addresses, words on multiples of four; 2'b11 never matches.
   function automatic logic access_legal(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SZ_BYTE: return 1'b1;
         SZ_HALF: return ~lane[0];
         SZ_WORD: return (lane == 2'b00);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SZ_BYTE: return 4'b0001 << lane;
         SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/datamem_load_align.sv
// Selects the addressed byte/half of a memory word and sign/zero extends it.
module datamem_load_align
   import datamem_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  lane_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (lane_i)
         2'd0:    byte_sel = word_i[7:0];
         2'd1:    byte_sel = word_i[15:8];
         2'd2:    byte_sel = word_i[23:16];
         default: byte_sel = word_i[31:24];
      endcase
      half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
   end

   always_comb begin
      case (size_i)
         SZ_BYTE: data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
         SZ_HALF: data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
         default: data_o = word_i;
      endcase
   end

endmodule

// File: rtl/datamem_bytelane.sv
// Byte-addressed data memory with lane-masked stores, registered extended loads
// and a one-word-per-cycle zeroing sweep after reset so the array maps to block RAM.
module datamem_bytelane
   import datamem_pkg::*;
#(
   parameter  int DEPTH  = 128,
   localparam int ADDR_W = $clog2(DEPTH) + 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [1:0]        size,
   input  logic              load_unsigned,
   input  logic [31:0]       write_data,
   output logic [31:0]       read_data,
   output logic              read_valid,
   output logic              busy,
   output logic              misaligned_err
);

   localparam int IDX_W = ADDR_W - 2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic              valid_q, err_q, err_d;
   logic [31:0]       hold_q;
   logic [31:0]       rd_word_q;
   logic [1:0]        lane_q, size_q;
   logic              uns_q;
   logic [31:0]       aligned;

   logic [31:0]       mem [DEPTH];
   logic              mem_we, load_acc;
   logic [3:0]        wr_be;
   logic [IDX_W-1:0]  wr_idx, rd_idx;
   logic [31:0]       wr_word;

   assign rd_idx = addr[ADDR_W-1:2];

   // NOTE: every signal assigned here gets a default first so no path infers a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mem_we   = 1'b0;
      wr_be    = 4'b0000;
      wr_idx   = cnt_q;
      wr_word  = 32'd0;
      load_acc = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         INIT: begin
            mem_we = 1'b1;
            wr_be  = 4'b1111;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) state_d = READY;
         end
         READY: begin
            wr_idx = rd_idx;
            if (mem_read || mem_write) begin
               if (!access_legal(size, addr[1:0])) begin
                  err_d = 1'b1;
               end else if (mem_read) begin
                  // Read wins over a simultaneous write; the write is silently dropped.
                  load_acc = 1'b1;
               end else begin
                  mem_we = 1'b1;
                  wr_be  = store_be(size, addr[1:0]);
                  case (size)
                     SZ_BYTE: wr_word = {4{write_data[7:0]}};
                     SZ_HALF: wr_word = {2{write_data[15:0]}};
                     default: wr_word = write_data;
                  endcase
               end
            end
         end
         default: state_d = INIT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= INIT;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         hold_q  <= 32'd0;
         lane_q  <= 2'b00;
         size_q  <= SZ_WORD;
         uns_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= load_acc;
         err_q   <= err_d;
         if (valid_q) hold_q <= aligned;
         if (load_acc) begin
            lane_q <= addr[1:0];
            size_q <= size;
            uns_q  <= load_unsigned;
         end
      end
   end

   // NOTE: the array and its read register carry no reset; the init sweep zeroes the contents.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int l = 0; l < 4; l++) begin
            if (wr_be[l]) mem[wr_idx][8*l +: 8] <= wr_word[8*l +: 8];
         end
      end
      if (load_acc) rd_word_q <= mem[rd_idx];
   end

   datamem_load_align u_align (
      .word_i     (rd_word_q),
      .lane_i     (lane_q),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .data_o     (aligned)
   );

   // The fresh result is shown during the valid cycle, then held until the next load.
   assign read_data      = valid_q ? aligned : hold_q;
   assign read_valid     = valid_q;
   assign misaligned_err = err_q;
   assign busy           = (state_q == INIT);

endmodule

// File: tb/tb_datamem_bytelane.sv
// Self-checking bench for datamem_bytelane: directed lane/extension cases plus
// randomized traffic against a byte-array reference model.
module tb_datamem_bytelane;
   import datamem_pkg::*;

   localparam int DEPTH = 128;
   localparam int AW    = $clog2(DEPTH) + 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          mem_read, mem_write, load_unsigned;
   logic [AW-1:0] addr;
   logic [1:0]    size;
   logic [31:0]   write_data, read_data;
   logic          read_valid, busy, misaligned_err;

   logic [7:0]    ref_mem [DEPTH*4];
   logic          exp_valid, exp_err;
   logic [31:0]   exp_data;
   int            passed = 0;
   int            total  = 0;

   always #5 clk = ~clk;

   datamem_bytelane #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .addr           (addr),
      .size           (size),
      .load_unsigned  (load_unsigned),
      .write_data     (write_data),
      .read_data      (read_data),
      .read_valid     (read_valid),
      .busy           (busy),
      .misaligned_err (misaligned_err)
   );

   task automatic clear_inputs();
      mem_read = 1'b0; mem_write = 1'b0; load_unsigned = 1'b0;
      addr = '0; size = SZ_WORD; write_data = 32'd0;
   endtask

   task automatic clear_model();
      for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
      exp_data = 32'd0; exp_valid = 1'b0; exp_err = 1'b0;
   endtask

   // Drives one request for one edge and advances the reference model.
   task automatic run_op(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [1:0] sz, input logic uns, input logic [31:0] wd);
      int n;
      logic [31:0] v;
      @(negedge clk);
      mem_read = rd; mem_write = wr; addr = a; size = sz;
      load_unsigned = uns; write_data = wd;
      n = 1 << sz;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (rd || wr) begin
         if (sz == 2'b11 || (int'(a) % n) != 0) begin
            exp_err = 1'b1;
         end else if (rd) begin
            v = 32'd0;
            for (int k = 0; k < n; k++) v = v | (32'(ref_mem[int'(a) + k]) << (8*k));
            if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            exp_data  = v;
            exp_valid = 1'b1;
         end else begin
            for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
         end
      end
      @(posedge clk); #1;
      clear_inputs();
   endtask

   task automatic wait_sweep(output int cycles, output int bad);
      cycles = 0;
      bad    = 0;
      while (busy === 1'b1 && cycles < 1000) begin
         @(posedge clk); #1;
         cycles++;
         if (read_valid !== 1'b0 || misaligned_err !== 1'b0) bad++;
      end
   endtask

   task automatic test_reset();
      int cycles, bad;
      clear_inputs();
      clear_model();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b1 || read_valid !== 1'b0 || read_data !== 32'd0 || misaligned_err !== 1'b0)
         $display("FAIL reset_values: busy=%b valid=%b data=%h err=%b required 1 0 00000000 0",
                  busy, read_valid, read_data, misaligned_err);
      else passed++;
      @(negedge clk);
      reset = 1'b0;
      mem_read = 1'b1; size = SZ_WORD; addr = '0;
      wait_sweep(cycles, bad);
      clear_inputs();
      total++;
      if (cycles !== DEPTH) $display("FAIL busy_length: got %0d cycles required %0d", cycles, DEPTH);
      else passed++;
      total++;
      if (bad !== 0) $display("FAIL pulse_during_busy: got %0d pulses required 0", bad);
      else passed++;
   endtask

   task automatic test_all_zero(input string tag);
      int bad = 0;
      for (int w = 0; w < DEPTH; w++) begin
         run_op(1'b1, 1'b0, AW'(w*4), SZ_WORD, 1'b0, 32'd0);
         if (read_valid !== 1'b1 || read_data !== 32'd0) begin
            bad++;
            if (bad < 4) $display("FAIL %s word %0d: valid=%b data=%h required 1 00000000",
                                  tag, w, read_valid, read_data);
         end
      end
      total++;
      if (bad == 0) passed++;
   endtask

   task automatic test_lanes();
      run_op(1'b0, 1'b1, 9'h10, SZ_WORD, 1'b0, 32'h8765_4321);
      run_op(1'b1, 1'b0, 9'h13, SZ_BYTE, 1'b0, 32'd0);
      total++;
      if (read_valid !== 1'b1 || read_data !== 32'hFFFF_FF87)
         $display("FAIL lb_signed_13: valid=%b data=%h required 1 ffffff87", read_valid, read_data);
      else passed++;
      run_op(1'b1, 1'b0, 9'h13, SZ_BYTE, 1'b1, 32'd0);
      total++;
      if (read_valid !== 1'b1 || read_data !== 32'h0000_0087)
         $display("FAIL lbu_13: valid=%b data=%h required 1 00000087", read_valid, read_data);
      else passed++;
      run_op(1'b1, 1'b0, 9'h12, SZ_HALF, 1'b0, 32'd0);
      total++;
      if (read_valid !== 1'b1 || read_data !== 32'hFFFF_8765)
         $display("FAIL lh_signed_12: valid=%b data=%h required 1 ffff8765", read_valid, read_data);
      else passed++;
      run_op(1'b1, 1'b0, 9'h10, SZ_BYTE, 1'b0, 32'd0);
      total++;
      if (read_valid !== 1'b1 || read_data !== 32'h0000_0021)
         $display("FAIL lb_10: valid=%b data=%h required 1 00000021", read_valid, read_data);
      else passed++;
      run_op(1'b0, 1'b0, 9'h00, SZ_WORD, 1'b0, 32'd0);
      total++;
      if (read_valid !== 1'b0 || read_data !== 32'h0000_0021)
         $display("FAIL read_hold: valid=%b data=%h required 0 00000021", read_valid, read_data);
      else passed++;
   endtask

   task automatic test_partial_store();
      run_op(1'b0, 1'b1, 9'h11, SZ_BYTE, 1'b0, 32'h5555_55AB);
      run_op(1'b0, 1'b1, 9'h12, SZ_HALF, 1'b0, 32'hCCCC_1234);
      run_op(1'b1, 1'b0, 9'h10, SZ_WORD, 1'b0, 32'd0);
      total++;
      if (read_valid !== 1'b1 || read_data !== 32'h1234_AB21)
         $display("FAIL merge_word_10: valid=%b data=%h required 1 1234ab21", read_valid, read_data);
      else passed++;
   endtask

   task automatic test_misaligned();
      run_op(1'b0, 1'b1, 9'h21, SZ_HALF, 1'b0, 32'h0000_BEEF);
      total++;
      if (misaligned_err !== 1'b1 || read_valid !== 1'b0)
         $display("FAIL sh_21_err: err=%b valid=%b required 1 0", misaligned_err, read_valid);
      else passed++;
      run_op(1'b0, 1'b0, 9'h00, SZ_WORD, 1'b0, 32'd0);
      total++;
      if (misaligned_err !== 1'b0)
         $display("FAIL err_one_cycle: err=%b required 0", misaligned_err);
      else passed++;
      run_op(1'b1, 1'b0, 9'h20, SZ_WORD, 1'b0, 32'd0);
      total++;
      if (read_valid !== 1'b1 || read_data !== 32'd0)
         $display("FAIL word_20_untouched: valid=%b data=%h required 1 00000000", read_valid, read_data);
      else passed++;
      run_op(1'b1, 1'b0, 9'h10, SZ_WORD, 1'b0, 32'd0);
      run_op(1'b1, 1'b0, 9'h22, SZ_WORD, 1'b0, 32'd0);
      total++;
      if (misaligned_err !== 1'b1 || read_valid !== 1'b0 || read_data !== 32'h1234_AB21)
         $display("FAIL lw_22_reject: err=%b valid=%b data=%h required 1 0 1234ab21",
                  misaligned_err, read_valid, read_data);
      else passed++;
      run_op(1'b1, 1'b0, 9'h10, 2'b11, 1'b0, 32'd0);
      total++;
      if (misaligned_err !== 1'b1 || read_valid !== 1'b0)
         $display("FAIL size_11_reject: err=%b valid=%b required 1 0", misaligned_err, read_valid);
      else passed++;
   endtask

   task automatic test_read_write_collision();
      run_op(1'b1, 1'b1, 9'h10, SZ_WORD, 1'b0, 32'hFFFF_FFFF);
      total++;
      if (read_valid !== 1'b1 || misaligned_err !== 1'b0 || read_data !== 32'h1234_AB21)
         $display("FAIL rw_collision: valid=%b err=%b data=%h required 1 0 1234ab21",
                  read_valid, misaligned_err, read_data);
      else passed++;
      run_op(1'b1, 1'b0, 9'h10, SZ_WORD, 1'b0, 32'd0);
      total++;
      if (read_valid !== 1'b1 || read_data !== 32'h1234_AB21)
         $display("FAIL rw_write_dropped: valid=%b data=%h required 1 1234ab21", read_valid, read_data);
      else passed++;
   endtask

   task automatic test_random();
      int bad = 0;
      int r;
      logic rd, wr;
      for (int i = 0; i < 400; i++) begin
         r  = int'($urandom_range(0, 7));
         rd = (r >= 1 && r <= 3) || r == 7;
         wr = (r >= 4);
         run_op(rd, wr, AW'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), $urandom);
         total++;
         if (read_valid !== exp_valid || misaligned_err !== exp_err || read_data !== exp_data) begin
            bad++;
            if (bad < 6)
               $display("FAIL random op %0d: valid=%b err=%b data=%h required %b %b %h",
                        i, read_valid, misaligned_err, read_data, exp_valid, exp_err, exp_data);
         end else passed++;
      end
   endtask

   task automatic test_reset_mid();
      int cycles, bad;
      run_op(1'b0, 1'b1, 9'h40, SZ_WORD, 1'b0, 32'hDEAD_BEEF);
      run_op(1'b1, 1'b0, 9'h40, SZ_WORD, 1'b0, 32'd0);
      #2 reset = 1'b1;
      #1;
      total++;
      if (busy !== 1'b1 || read_valid !== 1'b0 || read_data !== 32'd0 || misaligned_err !== 1'b0)
         $display("FAIL reset_mid_op: busy=%b valid=%b data=%h err=%b required 1 0 00000000 0",
                  busy, read_valid, read_data, misaligned_err);
      else passed++;
      @(negedge clk) reset = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b1) $display("FAIL busy_at_50: busy=%b required 1", busy);
      else passed++;
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      mem_write = 1'b1; addr = 9'h40; size = SZ_WORD; write_data = 32'hFFFF_FFFF;
      wait_sweep(cycles, bad);
      clear_inputs();
      clear_model();
      total++;
      if (cycles !== DEPTH || bad !== 0)
         $display("FAIL resweep: got %0d cycles %0d pulses required %0d cycles 0 pulses",
                  cycles, bad, DEPTH);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_all_zero("init_zero");
      test_lanes();
      test_partial_store();
      test_misaligned();
      test_read_write_collision();
      test_random();
      test_reset_mid();
      test_all_zero("after_reset_zero");
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
